regfile_sb: RTL

Parametrised multi-port register file with same-cycle write-to-read bypass and a per-register scoreboard of pending writes. It sits in the decode stage of the pipelined MIPS core. It generalises the fixed 2-read/1-write, 32x32 register file to configurable width, depth and port counts. It also gives the hazard unit a registered busy bit per architectural register, so decode can stall on outstanding producers.

---
 rtl/regfile_sb.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and a scoreboard
// of pending writes, feeding the decode-stage hazard unit.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREAD*ADDR_W-1:0]  rd_addr,
    output logic [NREAD*DATA_W-1:0]  rd_data,
    output logic [NREAD-1:0]         rd_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*ADDR_W-1:0] wr_addr,
    input  logic [NWRITE*DATA_W-1:0] wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic [ADDR_W-1:0] wa [NWRITE];
    logic [DATA_W-1:0] wd [NWRITE];
    logic [NWRITE-1:0] wr_ok;
    logic              iss_ok;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    for (genvar j = 0; j < NWRITE; j++) begin : g_wr
        assign wa[j]    = wr_addr[j*ADDR_W +: ADDR_W];
        assign wd[j]    = wr_data[j*DATA_W +: DATA_W];
        assign wr_ok[j] = wr_en[j] && !is_zero(wa[j]);
    end

    assign iss_ok = iss_en && !is_zero(iss_addr);

    // Later ports are applied last, so the highest index wins on collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j]) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Issue is applied after writeback: a new producer supersedes the old one
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wr_ok[j]) begin
                    busy_nxt[wa[j]] = 1'b0;
                end
            end
            if (iss_ok) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] d;
        logic              b;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            d = mem[ra];
            b = busy[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_ok[j] && (wa[j] == ra)) begin
                        d = wd[j];
                        b = 1'b0;
                    end
                end
            end
            if (is_zero(ra)) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = d;
        assign rd_busy[i]                  = b;
    end

endmodule
